// File: rtl/mem_access_unit.sv
// Memory access unit: pops one queued memory op at a time from the
// memory-op FIFO and runs it to completion (store, load or serial scan).
// Exports the Rd of the in-flight load/scan for decode hazard stalls.
module mem_access_unit #(
    parameter int DataWidth = 92,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [DataWidth-1:0] fifoData,
    output logic                 readEn,
    output logic                 memReq,
    output logic                 memWe,
    output logic [XLEN-1:0]      memAddr,
    output logic [XLEN-1:0]      memWdata,
    input  logic                 memReady,
    input  logic                 memRvalid,
    input  logic [XLEN-1:0]      memRdata,
    output logic                 scanReq,
    input  logic                 scanValid,
    input  logic [XLEN-1:0]      scanData,
    output logic                 wbEn,
    output logic [5:0]           wbRd,
    output logic [XLEN-1:0]      wbData,
    output logic [5:0]           busyRd,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SCAN,
        WB
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        rd_q, rd_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              store_q, store_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              entry_present;
    logic              entry_scan;
    logic              entry_write;
    logic              unused_fields;

    assign entry_present = |fifoData;
    assign entry_scan    = fifoData[1];
    assign entry_write   = fifoData[3];
    // PC and the two spare flag bits are carried for debug only
    assign unused_fields = ^{fifoData[21:4], fifoData[2], fifoData[0]};

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched op fields and the write-back value
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            result_q <= '0;
        end else begin
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (entry_present) begin
                    state_d = entry_scan ? SCAN : REQ;
                end
            end
            REQ: begin
                if (memReady) begin
                    state_d = store_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (memRvalid) begin
                    state_d = WB;
                end
            end
            SCAN: begin
                if (scanValid) begin
                    state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the popped entry and the returned load/scan word
    always_comb begin
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        result_d = result_q;
        if (state_q == IDLE && entry_present) begin
            rd_d    = fifoData[91:86];
            addr_d  = fifoData[85:54];
            wdata_d = fifoData[53:22];
            // scan wins when both scan and MemWrite are set
            store_d = entry_write & ~entry_scan;
        end
        if (state_q == WAIT && memRvalid) begin
            result_d = memRdata;
        end
        if (state_q == SCAN && scanValid) begin
            result_d = scanData;
        end
    end

    // Output decode; readEn is gated by rstN so reset forces every output low
    always_comb begin
        readEn   = 1'b0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        scanReq  = 1'b0;
        wbEn     = 1'b0;
        wbRd     = '0;
        wbData   = '0;
        busyRd   = '0;
        busy     = (state_q != IDLE);
        if (state_q != IDLE && !store_q) begin
            busyRd = rd_q;
        end
        case (state_q)
            IDLE: begin
                readEn = entry_present & rstN;
            end
            REQ: begin
                memReq   = 1'b1;
                memWe    = store_q;
                memAddr  = {addr_q[XLEN-1:2], 2'b00};
                memWdata = wdata_q;
            end
            SCAN: begin
                scanReq = 1'b1;
            end
            WB: begin
                wbEn   = (rd_q != '0);
                wbRd   = rd_q;
                wbData = result_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed op sequences plus a transaction-level
// model that predicts every handshake output on each falling clock edge.
module tb_mem_access_unit;

    logic        clk;
    logic        rstN;
    logic [91:0] fifoData;
    logic        readEn;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memReady;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        scanReq;
    logic        scanValid;
    logic [31:0] scanData;
    logic        wbEn;
    logic [5:0]  wbRd;
    logic [31:0] wbData;
    logic [5:0]  busyRd;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [91:0] fifo_q[$];

    mem_access_unit #(.DataWidth(92), .XLEN(32)) dut (
        .clk(clk), .rstN(rstN), .fifoData(fifoData), .readEn(readEn),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata),
        .scanReq(scanReq), .scanValid(scanValid), .scanData(scanData),
        .wbEn(wbEn), .wbRd(wbRd), .wbData(wbData), .busyRd(busyRd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [91:0] mk(input logic [5:0] rd, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [17:0] pc,
                                       input logic we, input logic sc, input logic [1:0] ign);
        return {rd, addr, wd, pc, we, ign[1], sc, ign[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // FIFO head presentation: follows the model's pops, settles before stimulus
    always @(posedge clk) begin
        #2;
        fifoData = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Transaction model: current op, whether memory accepted it, whether its
    // result word has arrived. kind 0 = store, 1 = load, 2 = scan.
    logic        m_busy = 1'b0;
    int          m_kind = 0;
    logic [5:0]  m_rd   = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd   = '0;
    logic        m_acc  = 1'b0;
    logic        m_have = 1'b0;
    logic [31:0] m_res  = '0;

    always @(negedge clk) begin
        logic       e_ren, e_mreq, e_sreq, e_wb;
        logic [5:0] e_brd;
        if (!rstN) begin
            chk("rst_readEn", readEn, 0);
            chk("rst_memReq", memReq, 0);
            chk("rst_scanReq", scanReq, 0);
            chk("rst_wbEn", wbEn, 0);
            chk("rst_busy", busy, 0);
            chk("rst_busyRd", busyRd, 0);
            m_busy = 1'b0;
            m_acc  = 1'b0;
            m_have = 1'b0;
        end else begin
            e_ren  = !m_busy && (fifoData != '0);
            e_mreq = m_busy && m_kind != 2 && !m_acc;
            e_sreq = m_busy && m_kind == 2 && !m_have;
            e_wb   = m_busy && m_have && m_rd != 0;
            e_brd  = (m_busy && m_kind != 0) ? m_rd : 6'd0;
            chk("m_readEn", readEn, e_ren);
            chk("m_memReq", memReq, e_mreq);
            chk("m_scanReq", scanReq, e_sreq);
            chk("m_wbEn", wbEn, e_wb);
            chk("m_busy", busy, m_busy);
            chk("m_busyRd", busyRd, e_brd);
            if (e_mreq) begin
                chk("m_memWe", memWe, (m_kind == 0));
                chk("m_memAddr", memAddr, {m_addr[31:2], 2'b00});
                if (m_kind == 0) chk("m_memWdata", memWdata, m_wd);
            end
            if (e_wb) begin
                chk("m_wbRd", wbRd, m_rd);
                chk("m_wbData", wbData, m_res);
            end
            if (!m_busy) begin
                if (fifoData != '0) begin
                    m_rd   = fifoData[91:86];
                    m_addr = fifoData[85:54];
                    m_wd   = fifoData[53:22];
                    m_kind = fifoData[1] ? 2 : (fifoData[3] ? 0 : 1);
                    m_busy = 1'b1;
                    m_acc  = 1'b0;
                    m_have = 1'b0;
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                end
            end else if (e_mreq) begin
                if (memReady) begin
                    m_acc = 1'b1;
                    if (m_kind == 0) m_busy = 1'b0;
                end
            end else if (e_sreq) begin
                if (scanValid) begin
                    m_have = 1'b1;
                    m_res  = scanData;
                end
            end else if (!m_have) begin
                if (memRvalid) begin
                    m_have = 1'b1;
                    m_res  = memRdata;
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    initial begin
        int pops[$];
        int wb_cnt;
        rstN      = 1'b0;
        fifoData  = '0;
        memReady  = 1'b0;
        memRvalid = 1'b0;
        memRdata  = '0;
        scanValid = 1'b0;
        scanData  = '0;
        step();
        step();
        rstN = 1'b1;
        step();
        step();
        chk("idle_readEn", readEn, 0);
        chk("idle_busy", busy, 0);

        // Load: Rd=5, addr 0x103 -> word address 0x100
        fifo_q.push_back(mk(6'd5, 32'h103, 32'h0, 18'h00abc, 1'b0, 1'b0, 2'b00));
        memReady = 1'b1;
        step();
        chk("ld_pop", readEn, 1);
        step();
        chk("ld_memReq", memReq, 1);
        chk("ld_memAddr", memAddr, 32'h100);
        chk("ld_memWe", memWe, 0);
        chk("ld_busyRd", busyRd, 5);
        step();
        memReady  = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 32'hDEADBEEF;
        chk("ld_wait_busyRd", busyRd, 5);
        step();
        memRvalid = 1'b0;
        chk("ld_wbEn", wbEn, 1);
        chk("ld_wbRd", wbRd, 5);
        chk("ld_wbData", wbData, 32'hDEADBEEF);
        step();
        chk("ld_done_busy", busy, 0);

        // Asynchronous reset while waiting on load data
        fifo_q.push_back(mk(6'd6, 32'h80, 32'h0, 18'h1, 1'b0, 1'b0, 2'b00));
        memReady = 1'b1;
        step();
        step();
        step();
        memReady = 1'b0;
        chk("rw_busyRd", busyRd, 6);
        rstN = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_busyRd0", busyRd, 0);
        chk("rw_memReq", memReq, 0);
        chk("rw_wbEn", wbEn, 0);
        chk("rw_scanReq", scanReq, 0);
        chk("rw_readEn", readEn, 0);
        step();
        step();
        rstN = 1'b1;
        step();
        step();
        chk("rw_post_readEn", readEn, 0);
        chk("rw_post_busy", busy, 0);

        // Store under backpressure, followed by a scan (MemWrite also set)
        scanValid = 1'b1;
        scanData  = 32'hBAD;
        fifo_q.push_back(mk(6'd7, 32'h40, 32'h12345678, 18'h1, 1'b1, 1'b0, 2'b11));
        fifo_q.push_back(mk(6'h22, 32'h0, 32'h0, 18'h5, 1'b1, 1'b1, 2'b00));
        step();
        chk("st_pop", readEn, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_memReq", memReq, 1);
            chk("st_memAddr", memAddr, 32'h40);
            chk("st_memWdata", memWdata, 32'h12345678);
            chk("st_memWe", memWe, 1);
            chk("st_busyRd", busyRd, 0);
            chk("st_readEn", readEn, 0);
            if (i == 3) begin
                memReady  = 1'b1;
                scanValid = 1'b0;
            end
        end
        step();
        memReady = 1'b0;
        chk("st_next_pop", readEn, 1);
        chk("st_wbEn", wbEn, 0);
        for (int j = 0; j < 4; j++) begin
            step();
            chk("sc_scanReq", scanReq, 1);
            chk("sc_busyRd", busyRd, 6'h22);
            chk("sc_memReq", memReq, 0);
            if (j == 3) begin
                scanValid = 1'b1;
                scanData  = 32'h7;
            end
        end
        step();
        scanValid = 1'b0;
        chk("sc_wbEn", wbEn, 1);
        chk("sc_wbRd", wbRd, 6'h22);
        chk("sc_wbData", wbData, 32'h7);
        step();
        chk("sc_done_busy", busy, 0);

        // Scan with Rd=0: word consumed, no write-back
        fifo_q.push_back(mk(6'd0, 32'h0, 32'h0, 18'h3, 1'b0, 1'b1, 2'b00));
        scanValid = 1'b1;
        scanData  = 32'h55;
        step();
        chk("z_pop", readEn, 1);
        step();
        chk("z_scanReq", scanReq, 1);
        chk("z_busyRd", busyRd, 0);
        step();
        scanValid = 1'b0;
        chk("z_wbEn", wbEn, 0);
        chk("z_busy", busy, 1);
        chk("z_scanReq_off", scanReq, 0);
        step();
        chk("z_done_busy", busy, 0);

        // Back-to-back loads, zero-wait memory, rvalid held high throughout
        memReady  = 1'b1;
        memRvalid = 1'b1;
        fifo_q.push_back(mk(6'd9, 32'h200, 32'h0, 18'h7, 1'b0, 1'b0, 2'b00));
        fifo_q.push_back(mk(6'h21, 32'h304, 32'h0, 18'h8, 1'b0, 1'b0, 2'b00));
        wb_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            memRdata = 32'hA0000000 + k;
            if (readEn) pops.push_back(k);
            if (wbEn) wb_cnt++;
        end
        memReady  = 1'b0;
        memRvalid = 1'b0;
        chk("bb_pop_count", pops.size(), 2);
        if (pops.size() == 2) chk("bb_pop_gap", pops[1] - pops[0], 4);
        chk("bb_wb_count", wb_cnt, 2);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
